// File: rtl/wave_pkg.sv
// Shared types and constants for the square-wave test-pattern generator
// and the wave-analysis path it feeds.
package wave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } wave_state_t;

    localparam logic [15:0] MID_LVL       = 16'd567;
    localparam logic [21:0] MIN_HALF_CNT  = 22'd3001;
    localparam logic [11:0] AMP_MAX_PP    = 12'd622;
    // Analyzer min-filter floor; AMP_MAX_PP keeps the low level above it.
    localparam logic [15:0] ANA_MIN_FLOOR = 16'd255;

    function automatic logic [21:0] clamp_half(input logic [21:0] req);
        return (req < MIN_HALF_CNT) ? MIN_HALF_CNT : req;
    endfunction

    function automatic logic [11:0] clamp_amp(input logic [11:0] req);
        return (req > AMP_MAX_PP) ? AMP_MAX_PP : req;
    endfunction

endpackage

// File: rtl/wave_synth_if.sv
// Control and sample bus of wave_synth: master drives the request side,
// slave (the generator) drives the sample/status side.
interface wave_synth_if;

    logic               start;
    logic               stop;
    logic        [21:0] freq;
    logic        [11:0] amp;
    logic signed [15:0] lft_out;
    logic signed [15:0] rght_out;
    logic               busy;
    logic               cycle_done;
    logic        [15:0] periods;

    modport master (
        output start, stop, freq, amp,
        input  lft_out, rght_out, busy, cycle_done, periods
    );

    modport slave (
        input  start, stop, freq, amp,
        output lft_out, rght_out, busy, cycle_done, periods
    );

endinterface

// File: rtl/wave_half_timer.sv
// Half-period timer: counts 0..half_len-1 while enabled, restarts at 0 on load.
module wave_half_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        load,
    input  logic [21:0] half_len,
    output logic        tc
);

    logic [21:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 22'd1;
        end
    end

    assign tc = (cnt == (half_len - 22'd1));

endmodule

// File: rtl/wave_synth.sv
// Square-wave generator centred on MID_LVL. Build with WAVE_SYNTH_RGHT_INV_EN
// defined to make rght_out the mirror of lft_out about MID_LVL.
//
//   state | meaning
//   IDLE  | both channels at MID_LVL, waiting for start
//   HIGH  | left channel at hi_lvl for half_len cycles
//   LOW   | left channel at lo_lvl for half_len cycles, then boundary
module wave_synth
    import wave_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         reset,
    wave_synth_if.slave  bus
);

    wave_state_t        state;
    logic        [21:0] half_len_q;
    logic        [15:0] hi_lvl_q;
    logic        [15:0] lo_lvl_q;
    logic               stop_pend;
    logic signed [15:0] lft_q;
    logic signed [15:0] rght_q;
    logic               busy_q;
    logic               cycle_done_q;
    logic        [15:0] periods_q;

    logic        [15:0] amp_w;
    logic        [15:0] hi_nxt;
    logic        [15:0] lo_nxt;
    logic        [21:0] half_nxt;
    logic               go;
    logic               load;
    logic               tc;

    // hi gets the odd half so hi_lvl - lo_lvl equals the clamped amplitude.
    assign amp_w    = {4'd0, clamp_amp(bus.amp)};
    assign lo_nxt   = MID_LVL - (amp_w >> 1);
    assign hi_nxt   = MID_LVL + (amp_w - (amp_w >> 1));
    assign half_nxt = clamp_half(bus.freq);
    assign go       = bus.start && !bus.stop;
    assign load     = (state == IDLE) ? go : tc;

    function automatic logic signed [15:0] rght_of(input logic [15:0] lvl);
`ifdef WAVE_SYNTH_RGHT_INV_EN
        return $signed((MID_LVL << 1) - lvl);
`else
        return $signed(lvl);
`endif
    endfunction

    wave_half_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (reset),
        .en       (state != IDLE),
        .load     (load),
        .half_len (half_len_q),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            half_len_q   <= MIN_HALF_CNT;
            hi_lvl_q     <= MID_LVL;
            lo_lvl_q     <= MID_LVL;
            stop_pend    <= 1'b0;
            lft_q        <= $signed(MID_LVL);
            rght_q       <= $signed(MID_LVL);
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            periods_q    <= '0;
        end else if (reset) begin
            state        <= IDLE;
            half_len_q   <= MIN_HALF_CNT;
            hi_lvl_q     <= MID_LVL;
            lo_lvl_q     <= MID_LVL;
            stop_pend    <= 1'b0;
            lft_q        <= $signed(MID_LVL);
            rght_q       <= $signed(MID_LVL);
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            periods_q    <= '0;
        end else begin
            cycle_done_q <= 1'b0;
            if (state != IDLE && bus.stop) begin
                stop_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (go) begin
                        state      <= HIGH;
                        half_len_q <= half_nxt;
                        hi_lvl_q   <= hi_nxt;
                        lo_lvl_q   <= lo_nxt;
                        lft_q      <= $signed(hi_nxt);
                        rght_q     <= rght_of(hi_nxt);
                        busy_q     <= 1'b1;
                    end
                end
                HIGH: begin
                    if (tc) begin
                        state  <= LOW;
                        lft_q  <= $signed(lo_lvl_q);
                        rght_q <= rght_of(lo_lvl_q);
                    end
                end
                LOW: begin
                    if (tc) begin
                        cycle_done_q <= 1'b1;
                        periods_q    <= periods_q + 16'd1;
                        // A stop arriving on the final LOW cycle still counts.
                        if (stop_pend || bus.stop) begin
                            state     <= IDLE;
                            stop_pend <= 1'b0;
                            lft_q     <= $signed(MID_LVL);
                            rght_q    <= $signed(MID_LVL);
                            busy_q    <= 1'b0;
                        end else begin
                            state      <= HIGH;
                            half_len_q <= half_nxt;
                            hi_lvl_q   <= hi_nxt;
                            lo_lvl_q   <= lo_nxt;
                            lft_q      <= $signed(hi_nxt);
                            rght_q     <= rght_of(hi_nxt);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    lft_q  <= $signed(MID_LVL);
                    rght_q <= $signed(MID_LVL);
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lft_out    = lft_q;
    assign bus.rght_out   = rght_q;
    assign bus.busy       = busy_q;
    assign bus.cycle_done = cycle_done_q;
    assign bus.periods    = periods_q;

endmodule

// File: tb/tb_wave_synth.sv
// Directed bench for wave_synth: levels, period timing, stop, resets, clamping.
module tb_wave_synth;

    logic clk;
    logic rst_n;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   t;

`ifdef WAVE_SYNTH_RGHT_INV_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    wave_synth_if bus ();

    wave_synth dut (
        .clk   (clk),
        .rst_n (rst_n),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_lvl(input string tag, input int exp);
        chk({tag, " lft"}, {16'd0, bus.lft_out}, 32'(exp));
        chk({tag, " rght"}, {16'd0, bus.rght_out}, INV ? 32'(1134 - exp) : 32'(exp));
    endtask

    task automatic pulse_start();
        t = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        t = 0;
        rst_n = 1'b0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.freq = 22'd4000;
        bus.amp = 12'd400;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk_lvl("reset", 567);
        chk("reset busy", {31'd0, bus.busy}, 0);
        chk("reset cycle_done", {31'd0, bus.cycle_done}, 0);
        chk("reset periods", {16'd0, bus.periods}, 0);

        // freq=4000 amp=400: 767/367
        pulse_start();
        chk_lvl("r1 first high", 767);
        chk("r1 busy", {31'd0, bus.busy}, 1);
        run_to(4000);
        chk_lvl("r1 last high", 767);
        run_to(4001);
        chk_lvl("r1 first low", 367);
        run_to(5000);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_lvl("start while busy", 367);
        run_to(8000);
        chk_lvl("r1 last low", 367);
        chk("r1 no early done", {31'd0, bus.cycle_done}, 0);
        run_to(8001);
        chk_lvl("r1 p2 high", 767);
        chk("r1 done p1", {31'd0, bus.cycle_done}, 1);
        chk("r1 periods 1", {16'd0, bus.periods}, 1);
        run_to(8002);
        chk("r1 done one cycle", {31'd0, bus.cycle_done}, 0);
        run_to(24000);
        chk("r1 periods 2", {16'd0, bus.periods}, 2);
        chk_lvl("r1 p3 last low", 367);
        run_to(24001);
        chk("r1 periods 3", {16'd0, bus.periods}, 3);
        chk("r1 done p3", {31'd0, bus.cycle_done}, 1);

        // mid-period change applies at next boundary: 768/367, half 5000
        run_to(24500);
        bus.freq = 22'd5000;
        bus.amp = 12'd401;
        run_to(28000);
        chk_lvl("old hi kept", 767);
        run_to(28001);
        chk_lvl("old lo kept", 367);
        run_to(32000);
        chk_lvl("old half kept", 367);
        run_to(32001);
        chk_lvl("odd amp hi", 768);
        chk("periods 4", {16'd0, bus.periods}, 4);
        run_to(37000);
        chk_lvl("new half last high", 768);
        run_to(37001);
        chk_lvl("odd amp lo", 367);
        run_to(42001);
        chk_lvl("p6 high", 768);
        chk("periods 5", {16'd0, bus.periods}, 5);

        // single-cycle stop mid-HIGH: finish HIGH and LOW then IDLE
        run_to(43000);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk_lvl("stop still high", 768);
        run_to(47001);
        chk_lvl("stop low phase", 367);
        run_to(52000);
        chk("stop busy before end", {31'd0, bus.busy}, 1);
        chk_lvl("stop last low", 367);
        run_to(52001);
        chk_lvl("stop idle", 567);
        chk("stop busy", {31'd0, bus.busy}, 0);
        chk("stop done", {31'd0, bus.cycle_done}, 1);
        chk("stop periods", {16'd0, bus.periods}, 6);
        run_to(52003);
        chk_lvl("stop stays idle", 567);
        chk("stop periods held", {16'd0, bus.periods}, 6);

        // clamping: freq=100 -> 3001, amp=1000 -> 622 -> 878/256
        bus.freq = 22'd100;
        bus.amp = 12'd1000;
        pulse_start();
        chk_lvl("clamp high", 878);
        run_to(3001);
        chk_lvl("clamp last high", 878);
        run_to(3002);
        chk_lvl("clamp low", 256);
        run_to(6002);
        chk_lvl("clamp last low", 256);
        run_to(6003);
        chk_lvl("clamp p2 high", 878);
        chk("clamp periods", {16'd0, bus.periods}, 7);

        // sync reset mid-LOW abandons the period
        run_to(10000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_lvl("sreset", 567);
        chk("sreset periods", {16'd0, bus.periods}, 0);
        chk("sreset done", {31'd0, bus.cycle_done}, 0);
        chk("sreset busy", {31'd0, bus.busy}, 0);
        tick();
        chk("sreset no late done", {31'd0, bus.cycle_done}, 0);
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        reset = 1'b0;
        bus.start = 1'b0;
        chk("reset beats start", {31'd0, bus.busy}, 0);

        // restart, amp=200 -> 667/467
        bus.amp = 12'd200;
        pulse_start();
        chk_lvl("restart high", 667);
        chk("restart busy", {31'd0, bus.busy}, 1);
        run_to(3002);
        chk_lvl("restart low", 467);

        // async reset takes effect without a clock edge
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_lvl("areset", 567);
        chk("areset busy", {31'd0, bus.busy}, 0);
        #3 rst_n = 1'b1;

        // start and stop together in IDLE: no activity
        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        chk("start+stop busy", {31'd0, bus.busy}, 0);
        chk_lvl("start+stop", 567);
        repeat (5) tick();
        chk("start+stop later busy", {31'd0, bus.busy}, 0);
        chk("start+stop periods", {16'd0, bus.periods}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
